fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Controller for the Instruction Fetch stage. Sequences the PC register and the instruction memory request, and drives the IF/ID pipeline register controls. It steps the PC, stalls on memory wait and hazards, redirects on taken branches and discards wrong-path fetches, including one still in flight when a branch resolves. It sits between the PC register (`in`/`freeze`/`out`), the instruction memory, the hazard unit and the EX-stage branch logic.

## Interface
- ADDR_W, 32, PC/address width
- PC_STEP, 4, byte increment per sequential instruction

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- pc_out  in  ADDR_W  current PC register value
- pc_in  out  ADDR_W  next value for PC register `in`
- pc_freeze  out  1  PC register `freeze`; 1 holds the PC
- imem_addr  out  ADDR_W  fetch address, always equal to pc_out
- imem_req  out  1  fetch request, held until imem_ready
- imem_ready  in  1  instruction valid this cycle; completes the request
- hazard  in  1  hazard-unit stall request
- branch_taken  in  1  one-cycle pulse from EX
- branch_addr  in  ADDR_W  branch target, valid with branch_taken
- if_valid  out  1  IF/ID loads the fetched instruction this edge
- if_flush  out  1  IF/ID clears to a bubble; overrides if_freeze
- if_freeze  out  1  IF/ID holds its contents; equals hazard

## Operation
- States: IDLE, FETCH, HOLD, DRAIN. Registers: state and pending[ADDR_W-1:0].
- Outputs are Mealy, combinational from state and inputs. pc_in defaults to pc_out + PC_STEP, modulo 2^ADDR_W (wraps, no carry out).
- When if_valid=0 and if_freeze=0, IF/ID loads a bubble.
- IDLE: imem_req=0, pc_freeze=1. Always moves to FETCH next cycle.
- FETCH: imem_req=1. Per-cycle priority:
  - branch_taken & imem_ready: pc_in=branch_addr, pc_freeze=0, if_flush=1, if_valid=0, stay FETCH. The returned instruction is dropped.
  - branch_taken & !imem_ready: pending<=branch_addr, pc_freeze=1, if_flush=1, go to DRAIN. imem_addr stays stable because the PC is frozen.
  - imem_ready & !hazard: if_valid=1, pc_freeze=0, stay FETCH.
  - imem_ready & hazard: the instruction is dropped, pc_freeze=1, go to HOLD.
  - !imem_ready: pc_freeze=1, if_valid=0, stay FETCH.
- HOLD: imem_req=0, pc_freeze=1.
  - branch_taken: pc_in=branch_addr, pc_freeze=0, if_flush=1, go to FETCH.
  - else !hazard: go to FETCH, which refetches the same PC.
- DRAIN: imem_req=1, if_valid=0.
  - branch_taken: pending<=branch_addr (newest wins), if_flush=1.
  - imem_ready: the instruction is dropped. pc_in=pending (or branch_addr if branch_taken in the same cycle), pc_freeze=0, go to FETCH.
  - else: pc_freeze=1.
  - hazard is ignored in DRAIN.
- A request is never abandoned while imem_req=1, except on rst.

## Timing
- rst high at an edge forces: state=IDLE, pending=0.
  - Outputs while rst is high: imem_req=0, pc_freeze=1, if_valid=0, if_flush=1.
  - The PC register and instruction memory share rst. The PC resets to 0 and any outstanding memory request is aborted.
- rst applies in any state, including mid-DRAIN. The pending target is lost.
- First request: the cycle after IDLE, i.e. 2 cycles after the rst=1 edge, with imem_addr=0.
- Throughput: 1 instruction/cycle when imem_ready=1 and hazard=0.
- Memory wait: each imem_ready=0 cycle adds 1 cycle; the PC holds.
- Branch penalty: the redirect takes effect at the next edge. The first target fetch occurs in the following cycle, or after the in-flight response arrives when in DRAIN.
- Hazard penalty: the dropped instruction plus one refetch. Minimum 2 cycles extra for a 1-cycle hazard.

## Test plan
- Reset, then imem_ready=1, hazard=0 -> IDLE one cycle, then if_valid=1 every cycle with imem_addr 0,4,8,12.
- imem_ready=0 for 3 cycles at PC=8 -> pc_freeze=1, if_valid=0, imem_req=1 and imem_addr=8 stable; 4th cycle if_valid=1, next PC=12.
- hazard=1 for 2 cycles arriving with imem_ready at PC=16 -> if_valid=0, HOLD with imem_req=0 for 2 cycles, then refetch at 16 with if_valid=1 once hazard=0.
- branch_taken with branch_addr=0x100 while imem_ready=1 at PC=0x24 -> if_flush=1, if_valid=0; next imem_addr=0x100.
- branch_taken with branch_addr=0x200 at PC=0x20 with imem_ready=0, ready arrives 2 cycles later -> imem_addr stays 0x20, response dropped, next imem_addr=0x200; a second branch to 0x300 during DRAIN -> next imem_addr=0x300.
- rst asserted in DRAIN with pending=0x200 -> pending=0, IDLE, first fetch at address 0; 0x200 is never fetched.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Instruction Fetch stage controller. Steps the PC register, issues the
//   instruction memory request, drives the IF/ID pipeline register controls,
//   stalls on memory wait and hazards, and redirects on taken branches. A
//   branch that resolves while a fetch is still in flight is parked in
//   `pending` until the wrong-path response has been drained.
//
// Ports
//   clk, rst       rising-edge clock, synchronous active-high reset
//   pc_out         current PC register value
//   pc_in          next value for the PC register
//   pc_freeze      1 holds the PC register
//   imem_addr      fetch address (always pc_out)
//   imem_req       fetch request, held until imem_ready
//   imem_ready     instruction valid this cycle; completes the request
//   hazard         hazard-unit stall request
//   branch_taken   one-cycle redirect pulse from EX
//   branch_addr    redirect target, valid with branch_taken
//   if_valid       IF/ID loads the fetched instruction this edge
//   if_flush       IF/ID clears to a bubble (overrides if_freeze)
//   if_freeze      IF/ID holds its contents (mirrors hazard)
module fetch_sequencer #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned PC_STEP = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc_in,
    output logic              pc_freeze,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_req,
    input  logic              imem_ready,
    input  logic              hazard,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_addr,
    output logic              if_valid,
    output logic              if_flush,
    output logic              if_freeze
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pending, pending_nxt;

    assign imem_addr = pc_out;
    assign if_freeze = hazard;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pending <= '0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
        end
    end

    // Mealy outputs: the PC only advances on a completed fetch or a redirect.
    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        pc_in       = pc_out + ADDR_W'(PC_STEP);
        pc_freeze   = 1'b1;
        imem_req    = 1'b0;
        if_valid    = 1'b0;
        if_flush    = 1'b0;
        if (rst) begin
            if_flush = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    state_nxt = FETCH;
                end
                FETCH: begin
                    imem_req = 1'b1;
                    if (branch_taken && imem_ready) begin
                        pc_in     = branch_addr;
                        pc_freeze = 1'b0;
                        if_flush  = 1'b1;
                    end else if (branch_taken) begin
                        // Request still outstanding: keep the PC (and hence
                        // imem_addr) stable and remember where to go.
                        pending_nxt = branch_addr;
                        if_flush    = 1'b1;
                        state_nxt   = DRAIN;
                    end else if (imem_ready && !hazard) begin
                        if_valid  = 1'b1;
                        pc_freeze = 1'b0;
                    end else if (imem_ready) begin
                        state_nxt = HOLD;
                    end
                end
                HOLD: begin
                    if (branch_taken) begin
                        pc_in     = branch_addr;
                        pc_freeze = 1'b0;
                        if_flush  = 1'b1;
                        state_nxt = FETCH;
                    end else if (!hazard) begin
                        state_nxt = FETCH;
                    end
                end
                DRAIN: begin
                    imem_req = 1'b1;
                    if (branch_taken) begin
                        pending_nxt = branch_addr;
                        if_flush    = 1'b1;
                    end
                    if (imem_ready) begin
                        // Newest branch wins over the parked target.
                        pc_in     = branch_taken ? branch_addr : pending;
                        pc_freeze = 1'b0;
                        state_nxt = FETCH;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] pc_in;
    logic        pc_freeze;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_ready;
    logic        hazard;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        if_valid;
    logic        if_flush;
    logic        if_freeze;
    logic [3:0]  ctl;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    fetch_sequencer #(.ADDR_W(32), .PC_STEP(4)) dut (
        .clk(clk), .rst(rst), .pc_out(pc), .pc_in(pc_in), .pc_freeze(pc_freeze),
        .imem_addr(imem_addr), .imem_req(imem_req), .imem_ready(imem_ready),
        .hazard(hazard), .branch_taken(branch_taken), .branch_addr(branch_addr),
        .if_valid(if_valid), .if_flush(if_flush), .if_freeze(if_freeze)
    );

    // PC register model sharing the reset
    always @(posedge clk) begin
        if (rst) pc <= 32'h0;
        else if (!pc_freeze) pc <= pc_in;
    end

    // {imem_req, pc_freeze, if_valid, if_flush}
    assign ctl = {imem_req, pc_freeze, if_valid, if_flush};

    // advance one clock, then apply inputs and let outputs settle
    task automatic step(input logic r, input logic rdy, input logic hz,
                        input logic br, input logic [31:0] ba);
        @(posedge clk);
        #1;
        rst = r; imem_ready = rdy; hazard = hz; branch_taken = br; branch_addr = ba;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; imem_ready = 1'b1; hazard = 1'b0; branch_taken = 1'b0; branch_addr = '0;
        step(1, 1, 0, 0, 0);
        nvec++; if (ctl !== 4'b0101) begin nerr++; $display("FAIL reset_ctl got=%b exp=0101", ctl); end
        nvec++; if (imem_addr !== 32'h0) begin nerr++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
        step(0, 1, 0, 0, 0);  // IDLE
        nvec++; if (ctl !== 4'b0100) begin nerr++; $display("FAIL idle_ctl got=%b exp=0100", ctl); end
    endtask

    task automatic test_stream;
        logic [31:0] exp_a;
        for (int i = 0; i < 2; i++) begin
            step(0, 1, 0, 0, 0);
            exp_a = 32'(i * 4);
            nvec++; if (ctl !== 4'b1010) begin nerr++; $display("FAIL stream_ctl%0d got=%b exp=1010", i, ctl); end
            nvec++; if (imem_addr !== exp_a) begin nerr++; $display("FAIL stream_addr%0d got=%h exp=%h", i, imem_addr, exp_a); end
            nvec++; if (pc_in !== exp_a + 32'd4) begin nerr++; $display("FAIL stream_pcin%0d got=%h exp=%h", i, pc_in, exp_a + 32'd4); end
        end
    endtask

    task automatic test_mem_wait;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0);
            nvec++; if (ctl !== 4'b1100) begin nerr++; $display("FAIL wait_ctl%0d got=%b exp=1100", i, ctl); end
            nvec++; if (imem_addr !== 32'h8) begin nerr++; $display("FAIL wait_addr%0d got=%h exp=8", i, imem_addr); end
        end
        step(0, 1, 0, 0, 0);
        nvec++; if (ctl !== 4'b1010) begin nerr++; $display("FAIL wait_done_ctl got=%b exp=1010", ctl); end
        nvec++; if (pc_in !== 32'hC) begin nerr++; $display("FAIL wait_done_pcin got=%h exp=c", pc_in); end
        step(0, 1, 0, 0, 0);
        nvec++; if (imem_addr !== 32'hC || ctl !== 4'b1010) begin nerr++; $display("FAIL wait_next got=%h/%b exp=c/1010", imem_addr, ctl); end
    endtask

    task automatic test_hazard;
        step(0, 1, 1, 0, 0);  // PC=16, instruction dropped
        nvec++; if ({ctl, if_freeze} !== 5'b11001) begin nerr++; $display("FAIL haz_drop got=%b exp=11001", {ctl, if_freeze}); end
        nvec++; if (imem_addr !== 32'h10) begin nerr++; $display("FAIL haz_addr got=%h exp=10", imem_addr); end
        step(0, 1, 1, 0, 0);  // HOLD, hazard still up
        nvec++; if ({ctl, if_freeze} !== 5'b01001) begin nerr++; $display("FAIL haz_hold1 got=%b exp=01001", {ctl, if_freeze}); end
        step(0, 1, 0, 0, 0);  // HOLD, hazard released
        nvec++; if ({ctl, if_freeze} !== 5'b01000) begin nerr++; $display("FAIL haz_hold2 got=%b exp=01000", {ctl, if_freeze}); end
        step(0, 1, 0, 0, 0);  // refetch
        nvec++; if (ctl !== 4'b1010 || imem_addr !== 32'h10) begin nerr++; $display("FAIL haz_refetch got=%b/%h exp=1010/10", ctl, imem_addr); end
        nvec++; if (pc_in !== 32'h14) begin nerr++; $display("FAIL haz_pcin got=%h exp=14", pc_in); end
    endtask

    task automatic test_branch;
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);  // 0x14..0x20
        step(0, 1, 0, 1, 32'h100);  // PC=0x24
        nvec++; if (imem_addr !== 32'h24) begin nerr++; $display("FAIL br_addr got=%h exp=24", imem_addr); end
        nvec++; if (ctl !== 4'b1001 || pc_in !== 32'h100) begin nerr++; $display("FAIL br_redirect got=%b/%h exp=1001/100", ctl, pc_in); end
        step(0, 1, 0, 1, 32'hFFFF_FFFC);
        nvec++; if (imem_addr !== 32'h100) begin nerr++; $display("FAIL br_target got=%h exp=100", imem_addr); end
        step(0, 1, 0, 0, 0);
        nvec++; if (ctl !== 4'b1010 || pc_in !== 32'h0) begin nerr++; $display("FAIL pc_wrap got=%b/%h exp=1010/0", ctl, pc_in); end
        step(0, 1, 0, 1, 32'h20);  // PC=0
        step(0, 0, 0, 1, 32'h200);  // PC=0x20, in flight
        nvec++; if (ctl !== 4'b1101 || imem_addr !== 32'h20) begin nerr++; $display("FAIL drain_enter got=%b/%h exp=1101/20", ctl, imem_addr); end
        step(0, 0, 0, 0, 0);
        nvec++; if (ctl !== 4'b1100 || imem_addr !== 32'h20) begin nerr++; $display("FAIL drain_wait got=%b/%h exp=1100/20", ctl, imem_addr); end
        step(0, 1, 1, 0, 0);  // hazard ignored here
        nvec++; if (ctl !== 4'b1000 || pc_in !== 32'h200) begin nerr++; $display("FAIL drain_done got=%b/%h exp=1000/200", ctl, pc_in); end
        step(0, 0, 0, 1, 32'h280);
        nvec++; if (imem_addr !== 32'h200) begin nerr++; $display("FAIL drain_target got=%h exp=200", imem_addr); end
        step(0, 0, 0, 1, 32'h300);  // second branch while draining
        nvec++; if (ctl !== 4'b1101) begin nerr++; $display("FAIL drain_rebr got=%b exp=1101", ctl); end
        step(0, 1, 0, 0, 0);
        nvec++; if (ctl !== 4'b1000 || pc_in !== 32'h300) begin nerr++; $display("FAIL drain_newest got=%b/%h exp=1000/300", ctl, pc_in); end
        step(0, 0, 0, 1, 32'h200);
        nvec++; if (imem_addr !== 32'h300) begin nerr++; $display("FAIL drain_target2 got=%h exp=300", imem_addr); end
    endtask

    task automatic test_reset_in_drain;
        step(1, 0, 0, 0, 0);  // now in DRAIN with pending=0x200
        nvec++; if (ctl !== 4'b0101) begin nerr++; $display("FAIL rstdrain_ctl got=%b exp=0101", ctl); end
        step(0, 1, 0, 0, 0);
        nvec++; if (ctl !== 4'b0100 || imem_addr !== 32'h0) begin nerr++; $display("FAIL rstdrain_idle got=%b/%h exp=0100/0", ctl, imem_addr); end
        step(0, 1, 0, 0, 0);
        nvec++; if (ctl !== 4'b1010 || imem_addr !== 32'h0 || pc_in !== 32'h4) begin nerr++; $display("FAIL rstdrain_fetch got=%b/%h/%h exp=1010/0/4", ctl, imem_addr, pc_in); end
        step(0, 1, 0, 0, 0);
        nvec++; if (imem_addr !== 32'h4) begin nerr++; $display("FAIL rstdrain_next got=%h exp=4", imem_addr); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_mem_wait();
        test_hazard();
        test_branch();
        test_reset_in_drain();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
